// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/ack bus between fetch stage and instruction memory
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with IF/ID register and one-entry stall hold buffer
// Optional FETCH_STATS_EN macro enables the fetch_count/stall_count statistics counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    fetch_stage_if.master      imem,
    input  logic               stall_d,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               valid_d,
    output logic [31:0]        instr_d,
    output logic [5:0]         op_d,
    output logic [31:0]        pc_plus4_d,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc4;
    logic        can_accept;
    logic [31:0] pc_next4;

    always_comb begin
        can_accept = !stall_d || !valid_d;
        pc_next4   = pc + 32'd4;
    end

    // Request is masked by reset directly so it drops the moment reset rises.
    assign imem.req  = (state == ST_FETCH) && !reset;
    assign imem.addr = pc;
    assign op_d      = instr_d[31:26];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            valid_d    <= 1'b0;
            instr_d    <= 32'd0;
            pc_plus4_d <= 32'd0;
            hold_instr <= 32'd0;
            hold_pc4   <= 32'd0;
        end else if (redirect) begin
            // Flush wins over stall: IF/ID becomes a NOP bubble and any buffered word is dropped.
            state   <= ST_FETCH;
            pc      <= redirect_pc;
            valid_d <= 1'b0;
            instr_d <= 32'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem.ack) begin
                        pc <= pc_next4;
                        if (can_accept) begin
                            instr_d    <= imem.rdata;
                            pc_plus4_d <= pc_next4;
                            valid_d    <= 1'b1;
                        end else begin
                            hold_instr <= imem.rdata;
                            hold_pc4   <= pc_next4;
                            state      <= ST_HOLD;
                        end
                    end else if (can_accept) begin
                        valid_d <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall_d) begin
                        instr_d    <= hold_instr;
                        pc_plus4_d <= hold_pc4;
                        valid_d    <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic load_ifid;

    always_comb begin
        load_ifid = !redirect &&
                    (((state == ST_FETCH) && imem.ack && can_accept) ||
                     ((state == ST_HOLD) && !stall_d));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (load_ifid)
                fetch_count <= fetch_count + 32'd1;
            if (valid_d && stall_d && !redirect)
                stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a queue-based reference model
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        ack_drv;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [5:0]  op_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int n_checks;
    int n_fail;

    fetch_stage_if imem();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[17:2]} ^ 32'h1357_9BDF;
    endfunction

    assign imem.ack   = ack_drv;
    assign imem.rdata = mem_word(imem.addr);

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem.master),
        .stall_d     (stall_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .valid_d     (valid_d),
        .instr_d     (instr_d),
        .op_d        (op_d),
        .pc_plus4_d  (pc_plus4_d),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: PC, the IF/ID contents, and the hold buffer as a queue of {word, pc+4}.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [63:0] hq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RPC; m_valid = 1'b0; m_instr = 32'd0; m_pc4 = 32'd0;
        hq.delete(); m_fetch = 32'd0; m_stall = 32'd0;
    endtask

    task automatic model_step(input logic a, input logic s, input logic r, input logic [31:0] rp);
        logic [63:0] e;
        logic can;
        can = !s || !m_valid;
        if (m_valid && s && !r) m_stall++;
        if (r) begin
            m_pc = rp; m_valid = 1'b0; m_instr = 32'd0; hq.delete();
        end else if (hq.size() > 0) begin
            if (!s) begin
                e = hq.pop_front();
                m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1'b1; m_fetch++;
            end
        end else if (a) begin
            if (can) begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_fetch++;
            end else begin
                hq.push_back({mem_word(m_pc), m_pc + 32'd4});
            end
            m_pc = m_pc + 32'd4;
        end else if (can) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("imem_req",   {31'd0, imem.req}, {31'd0, hq.size() == 0});
        if (hq.size() == 0) check("imem_addr", imem.addr, m_pc);
        check("valid_d",    {31'd0, valid_d}, {31'd0, m_valid});
        check("instr_d",    instr_d, m_instr);
        check("op_d",       {26'd0, op_d}, {26'd0, m_instr[31:26]});
        check("pc_plus4_d", pc_plus4_d, m_pc4);
`ifdef FETCH_STATS_EN
        check("fetch_count", fetch_count, m_fetch);
        check("stall_count", stall_count, m_stall);
`else
        check("fetch_count", fetch_count, 32'd0);
        check("stall_count", stall_count, 32'd0);
`endif
        if (valid_d && !stall_d)
            check("deliv_word", instr_d, mem_word(pc_plus4_d - 32'd4));
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic a, input logic s, input logic r, input logic [31:0] rp);
        ack_drv = a; stall_d = s; redirect = r; redirect_pc = rp;
        @(negedge clk);
        compare_all();
        model_step(a, s, r, rp);
        @(posedge clk);
        #1;
    endtask

    task automatic random_steps(input int n);
        logic [31:0] rp;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0)
                rp = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
            else
                rp = $urandom & 32'h0000_FFFF;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, rp);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; ack_drv = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        model_reset();
        @(posedge clk); #1;
        check("rst_req",   {31'd0, imem.req}, 32'd0);
        check("rst_valid", {31'd0, valid_d}, 32'd0);
        check("rst_instr", instr_d, 32'd0);
        check("rst_pc4",   pc_plus4_d, 32'd0);
        check("rst_addr",  imem.addr, RPC);
        @(posedge clk); #1;
        reset = 1'b0;

        // Sequential streaming
        step(1, 0, 0, 0);
        check("seq_addr1", imem.addr, 32'h0040_0004);
        check("seq_pc4_1", pc_plus4_d, 32'h0040_0004);
        step(1, 0, 0, 0);
        check("seq_addr2", imem.addr, 32'h0040_0008);
        check("seq_pc4_2", pc_plus4_d, 32'h0040_0008);

        // Three wait cycles at 0x400008
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check("wait_valid", {31'd0, valid_d}, 32'd0);
            check("wait_addr",  imem.addr, 32'h0040_0008);
        end
        step(1, 0, 0, 0);
        check("wait_deliv", instr_d, mem_word(32'h0040_0008));
        check("wait_pc4",   pc_plus4_d, 32'h0040_000C);

        // Stall four cycles with ack high
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            check("stall_req",   {31'd0, imem.req}, 32'd0);
            check("stall_instr", instr_d, mem_word(32'h0040_0008));
        end
        step(1, 0, 0, 0);
        check("rel_instr", instr_d, mem_word(32'h0040_000C));
        check("rel_pc4",   pc_plus4_d, 32'h0040_0010);
        check("rel_addr",  imem.addr, 32'h0040_0010);

        // Redirect during HOLD, then during an ack
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h0040_0100);
        check("rdh_valid", {31'd0, valid_d}, 32'd0);
        check("rdh_instr", instr_d, 32'd0);
        check("rdh_addr",  imem.addr, 32'h0040_0100);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0040_0100);
        check("rda_valid", {31'd0, valid_d}, 32'd0);
        check("rda_instr", instr_d, 32'd0);
        check("rda_addr",  imem.addr, 32'h0040_0100);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        check("wrap_addr", imem.addr, 32'd0);
        check("wrap_pc4",  pc_plus4_d, 32'd0);

        random_steps(400);

        // Asynchronous reset mid-operation
        #2;
        reset = 1'b1;
        #1;
        check("arst_req",   {31'd0, imem.req}, 32'd0);
        check("arst_valid", {31'd0, valid_d}, 32'd0);
        check("arst_instr", instr_d, 32'd0);
        check("arst_addr",  imem.addr, RPC);
        check("arst_fcnt",  fetch_count, 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        random_steps(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline. Holds the PC, issues one instruction-memory request per instruction, absorbs variable memory latency, and presents the fetched word, its PC+4 and a valid flag to the decode stage, where `op_d` drives the main decoder. Decode-side stall and branch/jump redirect are handled here, with a one-entry hold buffer so no fetched word is lost under stall.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_req`  out  1  fetch request; high only in FETCH state and reset low.
- `imem_addr`  out  32  current PC; meaningful when `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` for `imem_addr` this cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `stall_d`  in  1  decode stage cannot accept a new instruction.
- `redirect`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  32  new PC, valid with `redirect`.
- `valid_d`  out  1  IF/ID holds a live instruction.
- `instr_d`  out  32  IF/ID instruction word.
- `op_d`  out  6  `instr_d[31:26]`, combinational, to main decoder.
- `pc_plus4_d`  out  32  PC of `instr_d` plus 4 (branch/JAL link base).
- `fetch_count`  out  32  instructions delivered to IF/ID (see Configuration).
- `stall_count`  out  32  cycles with `valid_d`=1 and `stall_d`=1 (see Configuration).

## Operation
- Reset (async): `pc`=RESET_PC, state=FETCH, `valid_d`=0, `instr_d`=0, `pc_plus4_d`=0, hold buffer cleared, counters 0; `imem_req`=0 while `reset` high.
- IF/ID "can accept" = `!stall_d || !valid_d`.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. Memory samples address each cycle; a changed address abandons any prior request.
  - `redirect`: `pc`<=`redirect_pc`; any `imem_ack` this cycle discarded; stay FETCH.
  - `imem_ack` && can accept: IF/ID <= {`imem_rdata`, `pc`+4}, `valid_d`<=1, `pc`<=`pc`+4, stay FETCH.
  - `imem_ack` && !can accept: hold buffer <= {`imem_rdata`, `pc`+4}, `pc`<=`pc`+4, go HOLD.
  - no ack: hold `pc`; if can accept, `valid_d`<=0 (bubble).
- HOLD: `imem_req`=0.
  - `redirect`: drop buffer, `pc`<=`redirect_pc`, go FETCH.
  - `!stall_d`: IF/ID <= buffer, `valid_d`<=1, go FETCH.
  - else stay HOLD, IF/ID unchanged.
- Flush: `redirect` in any state forces `valid_d`<=0 and `instr_d`<=0 (harmless NOP) next edge, overriding `stall_d`.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000; bits [1:0] carried as given, no alignment check.
- Reset mid-operation: all state returns to reset values immediately; outstanding ack ignored.

## Timing
- Zero-wait memory (`imem_ack` tied 1): one instruction per cycle; ack in cycle N -> `valid_d`/`instr_d` updated at edge ending N, visible cycle N+1.
- Redirect in cycle N -> `imem_addr`=`redirect_pc` and `valid_d`=0 in cycle N+1; first redirected instruction valid N+2 at earliest.
- Stall: `instr_d`/`pc_plus4_d`/`valid_d` stable while `valid_d`&&`stall_d`; at most one word buffered; `imem_req` deasserts the cycle after buffer fills.
- Stall release from HOLD: buffered word in IF/ID next cycle, fetch resumes same cycle; no lost or duplicated instruction.
- `op_d` has zero latency from `instr_d`.

## Configuration
- `FETCH_STATS_EN` defined: `fetch_count` increments on every IF/ID load with `valid_d`<=1 (from memory or buffer); `stall_count` increments each cycle `valid_d`&&`stall_d`&&!`redirect`; both wrap at 2^32, cleared by reset.
- Undefined: counter logic omitted, both ports driven constant 0; all other behaviour identical.

## Test plan
- Reset with RESET_PC=32'h0040_0000, `imem_ack`=1, stream words -> `imem_addr` 0x400000, 0x400004, 0x400008; `pc_plus4_d` 0x400004, 0x400008; `valid_d` high from cycle 2.
- `imem_ack` low 3 cycles at 0x400008 -> `valid_d`=0 for 3 cycles, `imem_addr` stable, then word delivered once.
- `stall_d` high 4 cycles with ack=1 -> one word buffered, `imem_req`=0, `instr_d` unchanged; release -> next sequential words, none skipped or repeated.
- `redirect`=1, `redirect_pc`=0x400100 during HOLD and during ack -> buffer/ack dropped, `valid_d`=0, `instr_d`=0, next `imem_addr`=0x400100.
- `pc`=32'hFFFF_FFFC fetch -> next `imem_addr`=0, `pc_plus4_d`=0.
- With `FETCH_STATS_EN`: 10 deliveries, 3 stall cycles -> `fetch_count`=10, `stall_count`=3; without: both 0.
